// File: rtl/fetch_pc_gen.sv
// Instruction-fetch PC generator for the in-order RV64 front end.
// Owns the architectural fetch PC and keeps at most one request in flight on
// the instruction bus. The returned word is held in a single-entry buffer
// until decode accepts it. A redirect from execute steers fetch to a new PC;
// a response that is still owed to the bus for a wrong-path request is
// absorbed in FLUSH so the bus address never changes mid-request.
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request req_pc_q on the bus
    HOLD  = 2'd1,  // buffer full, waiting for decode
    FLUSH = 2'd2   // wrong-path request still owed a response
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic [63:0] target;
  logic        req_active;
  logic        unused_target_bits;

  // Instructions are 4-byte aligned; the low target bits are forced to zero.
  assign target             = {redirect_target[63:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];

  // Bus request is live in FETCH and FLUSH. The state register resets to
  // FETCH, so the request is also gated by reset_n to keep the bus quiet
  // while reset is held and to present RESET_PC as soon as it is released.
  assign req_active = (state_q == FETCH) || (state_q == FLUSH);
  assign ireq_valid = reset_n & req_active;
  assign ireq_addr  = ireq_valid ? req_pc_q : 64'd0;

  // Decode side: a redirect cycle must never complete a handshake.
  assign if_valid = buf_valid_q & ~redirect_valid;
  assign if_pc    = buf_pc_q;
  assign if_instr = buf_instr_q;

  // Next-state decode for the fetch FSM, redirect taking priority everywhere.
  always_comb begin
    // NOTE: every signal gets a default up front so no path infers a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
          if (iresp_data_ok) begin
            // Response retires the request; drop it and restart at target.
            req_pc_d = target;
          end else begin
            // Request still open; its response must be swallowed first.
            state_d = FLUSH;
          end
        end else if (iresp_data_ok) begin
          buf_valid_d = 1'b1;
          buf_pc_d    = req_pc_q;
          buf_instr_d = iresp_data;
          pc_d        = req_pc_q + 64'd4;  // wraps modulo 2^64
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          buf_valid_d = 1'b0;
          pc_d        = target;
          req_pc_d    = target;
          state_d     = FETCH;
        end else if (buf_valid_q && if_ready) begin
          buf_valid_d = 1'b0;
          req_pc_d    = pc_q;
          state_d     = FETCH;
        end
      end

      FLUSH: begin
        // Newest redirect wins; the bus address stays on the old request.
        if (redirect_valid) begin
          pc_d = target;
          if (iresp_data_ok) begin
            req_pc_d = target;
            state_d  = FETCH;
          end
        end else if (iresp_data_ok) begin
          req_pc_d = pc_q;
          state_d  = FETCH;
        end
      end

      default: begin
        state_d     = FETCH;
        buf_valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and buffer registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      // NOTE: the buffer payload is reset too so if_pc/if_instr read 0 in reset.
      buf_pc_q    <= 64'd0;
      buf_instr_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together.
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_fetch_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_gen #(.RESET_PC(64'h8000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ireq_valid      (ireq_valid),
    .ireq_addr       (ireq_addr),
    .iresp_data_ok   (iresp_data_ok),
    .iresp_data      (iresp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (one full clock cycle later).
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one cycle's inputs and let combinational outputs settle.
  task automatic drive(input logic ok, input logic [31:0] data, input logic rv,
                       input logic [63:0] rt, input logic rdy);
    iresp_data_ok   = ok;
    iresp_data      = data;
    redirect_valid  = rv;
    redirect_target = rt;
    if_ready        = rdy;
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    iresp_data_ok   = 1'b0;
    iresp_data      = 32'd0;
    redirect_valid  = 1'b0;
    redirect_target = 64'd0;
    if_ready        = 1'b0;

    // Reset state: all outputs zero.
    #1;
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_ireq_addr",  ireq_addr, 64'd0);
    chk("rst_if_valid",   {63'd0, if_valid}, 64'd0);
    chk("rst_if_pc",      if_pc, 64'd0);
    chk("rst_if_instr",   {32'd0, if_instr}, 64'd0);
    repeat (2) @(negedge clk);

    // Release: first request is RESET_PC.
    reset_n = 1'b1;
    #1;
    chk("rel_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rel_ireq_addr",  ireq_addr, 64'h8000_0000);

    // Zero-latency memory, decode always ready: fetch 0, 4, 8 alternating.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 64'd0, 1'b1);
      chk("seq_fetch_valid", {63'd0, ireq_valid}, 64'd1);
      chk("seq_fetch_addr",  ireq_addr, 64'h8000_0000 + 64'(4 * i));
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 64'd0, (i < 2) ? 1'b1 : 1'b0);
      chk("seq_hold_ireq",   {63'd0, ireq_valid}, 64'd0);
      chk("seq_if_valid",    {63'd0, if_valid}, 64'd1);
      chk("seq_if_pc",       if_pc, 64'h8000_0000 + 64'(4 * i));
      chk("seq_if_instr",    {32'd0, if_instr}, {32'd0, 32'hA000_0000 + 32'(i)});
      if (i < 2) next_cycle();
    end

    // Decode stalls for 5 cycles with the buffer full (first stall cycle above).
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
      chk("stall_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("stall_if_valid",   {63'd0, if_valid}, 64'd1);
      chk("stall_if_pc",      if_pc, 64'h8000_0008);
      chk("stall_if_instr",   {32'd0, if_instr}, {32'd0, 32'hA000_0002});
    end
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);  // accept
    next_cycle();
    drive(1'b1, 32'hA000_0003, 1'b0, 64'd0, 1'b1);
    chk("after_stall_addr", ireq_addr, 64'h8000_000C);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("pc_0c_if_pc", if_pc, 64'h8000_000C);
    next_cycle();

    // Request to 0x10 outstanding 3 cycles, redirect to 0x100 in cycle 1.
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("flush_c0_addr", ireq_addr, 64'h8000_0010);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 64'h8000_0100, 1'b1);
    chk("flush_c1_valid", {63'd0, ireq_valid}, 64'd1);
    chk("flush_c1_addr",  ireq_addr, 64'h8000_0010);
    next_cycle();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 64'd0, 1'b1);
    chk("flush_c2_valid", {63'd0, ireq_valid}, 64'd1);
    chk("flush_c2_addr",  ireq_addr, 64'h8000_0010);
    next_cycle();
    drive(1'b1, 32'hB000_0000, 1'b0, 64'd0, 1'b1);
    chk("flush_no_ifv",   {63'd0, if_valid}, 64'd0);
    chk("flush_new_addr", ireq_addr, 64'h8000_0100);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("flush_if_pc",    if_pc, 64'h8000_0100);
    chk("flush_if_instr", {32'd0, if_instr}, {32'd0, 32'hB000_0000});
    next_cycle();

    // Redirect in the same cycle as data_ok: response dropped, target aligned.
    drive(1'b1, 32'hBAD0_BAD0, 1'b1, 64'h8000_0203, 1'b1);
    chk("samecyc_addr", ireq_addr, 64'h8000_0104);
    next_cycle();
    drive(1'b1, 32'hC000_0000, 1'b0, 64'd0, 1'b1);
    chk("samecyc_no_ifv",   {63'd0, if_valid}, 64'd0);
    chk("samecyc_ireq_v",   {63'd0, ireq_valid}, 64'd1);
    chk("samecyc_new_addr", ireq_addr, 64'h8000_0200);
    next_cycle();

    // Redirect while in HOLD with decode ready: if_valid gated, buffer dropped.
    drive(1'b0, 32'd0, 1'b1, 64'h8000_0400, 1'b1);
    chk("hold_rd_if_valid", {63'd0, if_valid}, 64'd0);
    chk("hold_rd_buf_pc",   if_pc, 64'h8000_0200);
    next_cycle();
    drive(1'b1, 32'hD000_0000, 1'b0, 64'd0, 1'b0);
    chk("hold_rd_no_ifv", {63'd0, if_valid}, 64'd0);
    chk("hold_rd_addr",   ireq_addr, 64'h8000_0400);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
    chk("hold_rd_if_pc", if_pc, 64'h8000_0400);

    // Redirect to the top of the address space; next sequential PC wraps to 0.
    drive(1'b0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    next_cycle();
    drive(1'b1, 32'hE000_0000, 1'b0, 64'd0, 1'b1);
    chk("wrap_top_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("wrap_if_pc",    if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_if_instr", {32'd0, if_instr}, {32'd0, 32'hE000_0000});
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("wrap_valid", {63'd0, ireq_valid}, 64'd1);
    chk("wrap_addr",  ireq_addr, 64'd0);

    // Reset asserted mid-request: everything clears at once.
    reset_n = 1'b0;
    #1;
    chk("midrst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("midrst_ireq_addr",  ireq_addr, 64'd0);
    chk("midrst_if_pc",      if_pc, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("midrst_rel_addr", ireq_addr, 64'h8000_0000);

    // Two redirects during a pending request: the newest target wins.
    drive(1'b0, 32'd0, 1'b1, 64'h8000_0500, 1'b1);
    next_cycle();
    drive(1'b0, 32'd0, 1'b1, 64'h8000_0600, 1'b1);
    chk("newest_hold_addr", ireq_addr, 64'h8000_0000);
    next_cycle();
    drive(1'b1, 32'hF000_0000, 1'b0, 64'd0, 1'b1);
    chk("newest_pend_addr", ireq_addr, 64'h8000_0000);
    next_cycle();
    drive(1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
    chk("newest_no_ifv", {63'd0, if_valid}, 64'd0);
    chk("newest_addr",   ireq_addr, 64'h8000_0600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
